// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Segment bit order is {g,f,e,d,c,b,a}; segments and anodes are both active-low.
package display_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_state_t;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Full hex glyph set, lower-case b and d to keep them distinct from 8 and 0.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/display_7seg_mux_hex_a_7seg.sv
// Combinational 4-bit to seven-segment decoder, active-low outputs.
// Module name is hex_a_7seg so it reads the same as the rest of the board code.
module hex_a_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/display_7seg_mux.sv
// Four-slot multiplexed seven-segment driver with a shadowed digit load that is
// only applied at a frame boundary, so a frame never mixes old and new digits.
//
// state | meaning
// ------+------------------------------------------
// DIG0  | units slot, an=1110
// DIG1  | tens slot, an=1101
// DIG2  | hundreds slot, an=1011
// DIG3  | unused fourth digit, always blank, an=0111
module display_7seg_mux
  import display_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [3:0] h3,
  input  logic       cargar,
  input  logic       blank_ceros,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       ocupado
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] r_presc;
  logic          w_tick;
  dig_state_t    r_state;
  dig_state_t    w_state_nxt;

  logic [3:0] r_shadow_h1, r_shadow_h2, r_shadow_h3;
  logic [3:0] r_disp_h1, r_disp_h2, r_disp_h3;
  logic       r_ocupado;
  logic       w_frame_end;

  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic [6:0] w_seg_nxt;
  logic [3:0] w_an_nxt;
  logic       w_blank;
  logic [6:0] r_seg;
  logic [3:0] r_an;

  assign w_tick      = (r_presc == CW'(PRESCALE - 1));
  assign w_frame_end = w_tick && (r_state == DIG3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DIG0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      unique case (r_state)
        DIG0: w_state_nxt = DIG1;
        DIG1: w_state_nxt = DIG2;
        DIG2: w_state_nxt = DIG3;
        DIG3: w_state_nxt = DIG0;
      endcase
    end
  end

  // Capture and apply are mutually exclusive through ocupado, so a capture in the
  // boundary cycle waits for the next frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_h1 <= '0;
      r_shadow_h2 <= '0;
      r_shadow_h3 <= '0;
      r_disp_h1   <= '0;
      r_disp_h2   <= '0;
      r_disp_h3   <= '0;
      r_ocupado   <= 1'b0;
    end else if (cargar && !r_ocupado) begin
      r_shadow_h1 <= h1;
      r_shadow_h2 <= h2;
      r_shadow_h3 <= h3;
      r_ocupado   <= 1'b1;
    end else if (w_frame_end && r_ocupado) begin
      r_disp_h1 <= r_shadow_h1;
      r_disp_h2 <= r_shadow_h2;
      r_disp_h3 <= r_shadow_h3;
      r_ocupado <= 1'b0;
    end
  end

  always_comb begin
    w_digit  = r_disp_h1;
    w_an_nxt = AN_DIG0;
    w_blank  = 1'b0;
    unique case (r_state)
      DIG0: begin
        w_digit  = r_disp_h1;
        w_an_nxt = AN_DIG0;
      end
      DIG1: begin
        w_digit  = r_disp_h2;
        w_an_nxt = AN_DIG1;
        w_blank  = blank_ceros && (r_disp_h3 == 4'd0) && (r_disp_h2 == 4'd0);
      end
      DIG2: begin
        w_digit  = r_disp_h3;
        w_an_nxt = AN_DIG2;
        w_blank  = blank_ceros && (r_disp_h3 == 4'd0);
      end
      DIG3: begin
        w_an_nxt = AN_DIG3;
        w_blank  = 1'b1;
      end
    endcase
  end

  hex_a_7seg u_dec (
    .i_hex (w_digit),
    .o_seg (w_seg_dec)
  );

  assign w_seg_nxt = w_blank ? SEG_BLANK : w_seg_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign dp      = 1'b1;
  assign ocupado = r_ocupado;

endmodule
